// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer_if
// Description : FIFO read port plus packed valid/ready output stream.
//               The master modport is the packer; the slave modport is the
//               surrounding FIFO and downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
);
    // FIFO read side (first-word-fall-through)
    logic                             empty;
    logic [DATA_WIDTH-1:0]            rd_data;
    logic                             r_inc;

    // Packed output stream
    logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
    logic [PACK_RATIO-1:0]            out_keep;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        input  empty,
        input  rd_data,
        output r_inc,
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output empty,
        output rd_data,
        input  r_inc,
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Pops PACK_RATIO FIFO words and packs them little-endian into
//               one wide beat behind a single valid/ready output register.
//               Define FIFO_RD_PACKER_TIMEOUT_EN to flush partial beats after
//               TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_rd_packer_if.master  bus
);

    localparam int C_CNT_W = $clog2(PACK_RATIO);
    localparam int C_ACC_W = DATA_WIDTH * (PACK_RATIO - 1);
    localparam int C_OUT_W = DATA_WIDTH * PACK_RATIO;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(PACK_RATIO - 1);

    if (PACK_RATIO < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT >= 1");
    end

    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_ACC_W-1:0]    r_acc;
    logic [C_OUT_W-1:0]    r_out_data;
    logic [PACK_RATIO-1:0] r_out_keep;
    logic                  r_out_valid;

    logic                  w_out_free;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_load_full;
    logic                  w_flush;
    logic [PACK_RATIO-1:0] w_part_keep;

    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_last      = (r_cnt == C_LAST);
    // Lane-fill pops may proceed under stall; only the completing pop needs room.
    assign w_pop       = !rst && !bus.empty && (!w_last || w_out_free);
    assign w_load_full = w_pop && w_last;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int C_IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [C_IDLE_W-1:0] C_TIMEOUT = C_IDLE_W'(TIMEOUT);

    logic [C_IDLE_W-1:0] r_idle;

    // A coinciding pop always wins over the flush.
    assign w_flush = (r_cnt != '0) && !w_pop && (r_idle >= C_TIMEOUT) && w_out_free;

    always_comb begin
        w_part_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            w_part_keep[i] = (C_CNT_W'(i) < r_cnt);
        end
    end

    // Saturates at TIMEOUT so a flush blocked by backpressure stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_pop || w_flush) begin
            r_idle <= '0;
        end else if ((r_cnt != '0) && (r_idle < C_TIMEOUT)) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_flush     = 1'b0;
    assign w_part_keep = '0;
`endif

    // Lane counter and accumulator; unfilled lanes are always zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_pop) begin
            if (w_last) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                for (int i = 0; i < PACK_RATIO - 1; i++) begin
                    if (r_cnt == C_CNT_W'(i)) begin
                        r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= bus.rd_data;
                    end
                end
            end
        end else if (w_flush) begin
            r_cnt <= '0;
            r_acc <= '0;
        end
    end

    // A new load in the accept cycle replaces the old beat without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load_full) begin
            r_out_data  <= {bus.rd_data, r_acc};
            r_out_keep  <= '1;
            r_out_valid <= 1'b1;
        end else if (w_flush) begin
            r_out_data  <= {{DATA_WIDTH{1'b0}}, r_acc};
            r_out_keep  <= w_part_keep;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.r_inc     = w_pop;
    assign bus.out_data  = r_out_data;
    assign bus.out_keep  = r_out_keep;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Scoreboard bench for fifo_rd_packer driven by a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       checks     = 0;
    int       failures   = 0;
    int       pop_count  = 0;
    int       beat_count = 0;
    bit       gap_mode   = 1'b0;
    logic [7:0] fifo_q[$];
    beat_t    exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int c;
        c = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && c < maxc) begin
            tick(1);
            c++;
        end
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got words=%0d beats=%0d pending expected 0", name,
                     fifo_q.size(), exp_q.size());
        end
    endtask

    // FIFO model: pops on R_INC at the edge, presents new head just after it.
    initial begin
        bit gap_phase;
        gap_phase   = 1'b0;
        bus.empty   = 1'b1;
        bus.rd_data = '0;
        forever begin
            @(posedge clk);
            if (bus.r_inc) begin
                checks++;
                if (bus.empty || rst) begin
                    failures++;
                    $display("FAIL r_inc_guard: got r_inc=1 with empty=%b rst=%b expected 0",
                             bus.empty, rst);
                end else begin
                    void'(fifo_q.pop_front());
                    pop_count++;
                end
            end
            #1;
            gap_phase   = !gap_phase;
            bus.empty   = (fifo_q.size() == 0) || (gap_mode && gap_phase);
            bus.rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h keep %b expected no beat",
                         bus.out_data, bus.out_keep);
            end else begin
                chk("beat_data", bus.out_data, exp_q[0].data);
                chk("beat_keep", {28'b0, bus.out_keep}, {28'b0, exp_q[0].keep});
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    beat_count++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc0;
        int bc0;
        rst           = 1'b1;
        bus.out_ready = 1'b1;

        // Reset with data waiting and downstream ready
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        tick(1);
        repeat (2) begin
            @(negedge clk);
            chk("rst_r_inc", {31'b0, bus.r_inc}, 32'd0);
            chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("rst_data", bus.out_data, 32'd0);
            chk("rst_keep", {28'b0, bus.out_keep}, 32'd0);
        end

        // Basic pack
        push_exp(32'h44332211, 4'hF);
        pc0 = pop_count;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("basic", 20);
        chk("basic_pops", pop_count - pc0, 32'd4);

        // Backpressure
        bus.out_ready = 1'b0;
        pc0 = pop_count;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        push_exp(32'h04030201, 4'hF);
        push_exp(32'h08070605, 4'hF);
        tick(20);
        chk("bp_pops", pop_count - pc0, 32'd7);
        @(negedge clk);
        chk("bp_r_inc_low", {31'b0, bus.r_inc}, 32'd0);
        chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_eighth_pop", {31'b0, bus.r_inc}, 32'd1);
        @(negedge clk);
        chk("bp_no_bubble", {31'b0, bus.out_valid}, 32'd1);
        wait_idle("bp", 20);

        // Empty gaps
        gap_mode = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
        push_exp(32'hA4A3A2A1, 4'hF);
        push_exp(32'hA8A7A6A5, 4'hF);
        wait_idle("gaps", 60);
        gap_mode = 1'b0;
        tick(2);

        // Partial beat timeout
        pc0 = pop_count;
        bc0 = beat_count;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        push_exp(32'h0000BBAA, 4'b0011);
        wait_idle("timeout", 60);
        chk("timeout_beats", beat_count - bc0, 32'd1);
`else
        tick(100);
        chk("no_timeout_beats", beat_count - bc0, 32'd0);
`endif
        chk("timeout_pops", pop_count - pc0, 32'd2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset mid-operation discards partial lanes
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push_exp(32'h40302010, 4'hF);
        fifo_q.push_back(8'h10);
        fifo_q.push_back(8'h20);
        fifo_q.push_back(8'h30);
        fifo_q.push_back(8'h40);
        wait_idle("rst_midop", 30);
        tick(3);
        @(negedge clk);
        chk("final_idle", {31'b0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the FIFO, clocked in the read domain. It pops FIFO_DEPTH-agnostic DATA_WIDTH words via R_INC/EMPTY/RD_DATA and packs PACK_RATIO consecutive words into one wide beat. The wide beat is presented on a valid/ready output stream with a one-beat output register. It is the stage directly downstream of the FIFO read port and supplies the wider datapath.

## Interface
- DATA_WIDTH, 8, width of one FIFO word
- PACK_RATIO, 4, FIFO words per output beat (>=2)
- TIMEOUT, 16, idle cycles before a partial beat is flushed (used only with FIFO_RD_PACKER_TIMEOUT_EN; >=1)

- CLK  in  1  read-domain clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- EMPTY  in  1  FIFO empty flag; RD_DATA valid when low
- RD_DATA  in  DATA_WIDTH  FIFO head word (first-word-fall-through)
- R_INC  out  1  pop request to FIFO, combinational
- OUT_DATA  out  DATA_WIDTH*PACK_RATIO  packed beat
- OUT_KEEP  out  PACK_RATIO  per-lane valid mask
- OUT_VALID  out  1  beat valid
- OUT_READY  in  1  downstream accept

## Operation
- State: lane counter cnt (0..PACK_RATIO-1), accumulator acc (PACK_RATIO-1 lanes), output register (OUT_DATA/OUT_KEEP/OUT_VALID).
- Lane order little-endian: first popped word -> OUT_DATA[DATA_WIDTH-1:0].
- out_free = !OUT_VALID || OUT_READY.
- R_INC = !RST && !EMPTY && (cnt != PACK_RATIO-1 || out_free).
- Pop with cnt < PACK_RATIO-1: RD_DATA -> acc lane cnt, cnt+1.
- Pop with cnt == PACK_RATIO-1: {RD_DATA, acc} -> OUT_DATA, OUT_KEEP = all ones, OUT_VALID=1, cnt=0, acc cleared.
- OUT_VALID && OUT_READY with no new load: OUT_VALID=0 next edge; OUT_DATA/OUT_KEEP hold.
- Simultaneous accept and load: new beat replaces old in same edge, OUT_VALID stays 1 (no bubble).
- OUT_DATA/OUT_KEEP stable while OUT_VALID && !OUT_READY.
- R_INC never asserted while EMPTY=1 or RST=1.
- Only lane-fill pops are allowed during stall; the completing pop waits for out_free.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_KEEP=0, cnt=0, acc=0; R_INC=0 while RST=1.
- Reset mid-operation: partial lanes and any unaccepted beat are discarded; the next pop after RST falls lands in lane 0.
- Latency: the completing pop at edge N -> OUT_VALID=1 after edge N.
- Throughput: 1 FIFO word/cycle sustained with OUT_READY=1; 1 beat per PACK_RATIO cycles.
- Backpressure: with OUT_VALID=1 and OUT_READY=0, at most PACK_RATIO-1 further pops occur, then R_INC=0 until out_free.
- Wrap-around: cnt returns to 0 after lane PACK_RATIO-1; no other wrap state.

## Configuration
- FIFO_RD_PACKER_TIMEOUT_EN defined:
  - Idle counter increments each cycle with cnt>0 and no pop; it clears on any pop or flush.
  - When it reaches TIMEOUT and out_free, a partial beat is loaded: filled lanes from acc, unfilled lanes 0, OUT_KEEP bit i=1 for i<cnt; then cnt=0.
  - If a pop and a flush coincide, the pop wins and the counter clears.
- Not defined:
  - No idle counter; partial lanes are held indefinitely.
  - OUT_KEEP is all ones whenever OUT_VALID=1 (0 after reset).

## Test plan
- Reset: RST=1 for 2 cycles with EMPTY=0, OUT_READY=1 -> R_INC=0, OUT_VALID=0, OUT_DATA=0, OUT_KEEP=0 throughout.
- Basic pack: FIFO holds 11,22,33,44, OUT_READY=1 -> 4 consecutive R_INC pulses; 1 cycle after the 4th pop, OUT_DATA=0x44332211, OUT_KEEP=4'hF, OUT_VALID for exactly 1 cycle.
- Backpressure: FIFO holds 01..08, OUT_READY=0:
  - 0x04030201 is held stable.
  - Exactly 7 pops occur, then R_INC=0.
  - Raising OUT_READY -> 8th pop in that cycle; next beat 0x08070605 follows with no bubble.
- Empty gaps: EMPTY toggles 1/0 every cycle while A1..A8 are supplied -> R_INC never high with EMPTY=1; beats 0xA4A3A2A1 and 0xA8A7A6A5 in order.
- Timeout (macro defined, TIMEOUT=16): pop AA,BB then EMPTY=1 -> after 16 idle cycles OUT_DATA=0x0000BBAA, OUT_KEEP=4'b0011. With macro undefined -> no beat after 100 cycles.
- Reset mid-op: pop 01,02, pulse RST, then pop 10,20,30,40 -> single beat 0x40302010; no beat ever contains 01 or 02.
